// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: branch condition codes, resolve-stage FSM
// states and the control-transfer info bundle carried through ID/EX.
package pipeline_pkg;

  // RV32I branch funct3 encodings (010/011 are reserved)
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  // RUN: normal capture; SHADOW: the cycle after a redirect, wrong-path slot
  typedef enum logic {
    RUN    = 1'b0,
    SHADOW = 1'b1
  } br_state_e;

  // Control-transfer descriptor shared with the ID/EX register
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
  } br_info_t;

  function automatic logic is_ctrl_xfer(input br_info_t info);
    return info.is_branch | info.is_jal | info.is_jalr;
  endfunction

  function automatic logic is_reserved_br(input logic [2:0] funct3);
    return (funct3 == 3'b010) || (funct3 == 3'b011);
  endfunction

endpackage

// File: rtl/branch_resolve_stage_if.sv
// Bundle of the resolve stage's instruction inputs and result outputs.
// master = upstream/ID-EX side driving instructions, slave = the stage.
interface branch_resolve_stage_if;
  logic        valid_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] pc_i;
  logic [31:0] imm_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [2:0]  funct3_i;
  logic        is_branch_i;
  logic        is_jal_i;
  logic        is_jalr_i;

  logic        valid_o;
  logic        taken_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] link_o;
  logic        flush_o;
  logic        illegal_o;
  logic        misalign_o;
  logic [31:0] br_cnt_o;
  logic [31:0] taken_cnt_o;

  modport master (
    output valid_i, stall_i, flush_i, pc_i, imm_i, rs1_data_i, rs2_data_i,
           funct3_i, is_branch_i, is_jal_i, is_jalr_i,
    input  valid_o, taken_o, redirect_o, redirect_pc_o, link_o, flush_o,
           illegal_o, misalign_o, br_cnt_o, taken_cnt_o
  );

  modport slave (
    input  valid_i, stall_i, flush_i, pc_i, imm_i, rs1_data_i, rs2_data_i,
           funct3_i, is_branch_i, is_jal_i, is_jalr_i,
    output valid_o, taken_o, redirect_o, redirect_pc_o, link_o, flush_o,
           illegal_o, misalign_o, br_cnt_o, taken_cnt_o
  );
endinterface

// File: rtl/branch_resolve_stage_cond.sv
// Branch condition evaluation: one unsigned comparator plus a sign fix-up
// gives all six RV32I conditions. Reserved encodings evaluate false.
module branch_cond
  import pipeline_pkg::*;
(
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [2:0]  funct3_i,
  output logic        cond_true_o
);
  logic eq;
  logic ugt;
  logic ult;
  logic slt;

  compare_32bit_u u_cmp (
    .a_i   (rs1_i),
    .b_i   (rs2_i),
    .eq_o  (eq),
    .ugt_o (ugt),
    .ult_o (ult)
  );

  // Differing signs decide signed order directly; otherwise unsigned order holds
  assign slt = (rs1_i[31] ^ rs2_i[31]) ? rs1_i[31] : ult;

  // Select the condition named by funct3
  always_comb begin
    cond_true_o = 1'b0;
    case (funct3_i)
      BR_BEQ:  cond_true_o = eq;
      BR_BNE:  cond_true_o = ~eq;
      BR_BLT:  cond_true_o = slt;
      BR_BGE:  cond_true_o = ~slt;
      BR_BLTU: cond_true_o = ult;
      BR_BGEU: cond_true_o = eq | ugt;
      default: cond_true_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/compare_32bit_u.sv
// Unsigned 32-bit magnitude comparator.
module compare_32bit_u (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        eq_o,
  output logic        ugt_o,
  output logic        ult_o
);
  assign eq_o  = (a_i == b_i);
  assign ugt_o = (a_i >  b_i);
  assign ult_o = (a_i <  b_i);
endmodule

// File: rtl/branch_resolve_stage.sv
// Execute-side branch resolution: evaluates the condition, computes the
// target, and issues a registered one-cycle redirect/flush. The cycle after
// a redirect is a shadow slot whose incoming instruction is wrong-path.
module branch_resolve_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                   clk_i,
  input logic                   rst_i,
  branch_resolve_stage_if.slave bus
);
  br_info_t    info;
  logic        cond_true;
  logic [31:0] br_target;
  logic [31:0] jalr_sum;
  logic [31:0] target;
  logic        take_raw;
  logic        take;
  logic        misalign;
  logic        illegal;
  logic        capture;

  br_state_e   state_q, state_d;
  logic        valid_q, valid_d;
  logic        taken_q, taken_d;
  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] link_q, link_d;
  logic        illegal_q, illegal_d;
  logic        misalign_q, misalign_d;
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] taken_cnt_q, taken_cnt_d;

  assign info = '{pc:        bus.pc_i,
                  imm:       bus.imm_i,
                  is_branch: bus.is_branch_i,
                  is_jal:    bus.is_jal_i,
                  is_jalr:   bus.is_jalr_i};

  branch_cond u_cond (
    .rs1_i       (bus.rs1_data_i),
    .rs2_i       (bus.rs2_data_i),
    .funct3_i    (bus.funct3_i),
    .cond_true_o (cond_true)
  );

  // Targets wrap modulo 2^32; jalr clears bit 0 of its sum
  assign br_target = info.pc + info.imm;
  assign jalr_sum  = bus.rs1_data_i + info.imm;
  assign target    = info.is_jalr ? {jalr_sum[31:1], 1'b0} : br_target;

  // A target with bit 1 set cannot be fetched: report it instead of redirecting
  assign take_raw = info.is_jal | info.is_jalr | (info.is_branch & cond_true);
  assign misalign = take_raw & target[1];
  assign take     = take_raw & ~target[1];
  assign illegal  = info.is_branch & is_reserved_br(bus.funct3_i);

  assign capture = bus.valid_i & ~bus.stall_i & ~bus.flush_i & (state_q == RUN);

  // Next-state: flush beats stall; stall freezes everything but the pulse
  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    taken_d       = taken_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    link_d        = link_q;
    illegal_d     = illegal_q;
    misalign_d    = misalign_q;
    br_cnt_d      = br_cnt_q;
    taken_cnt_d   = taken_cnt_q;

    if (bus.flush_i) begin
      state_d    = RUN;
      valid_d    = 1'b0;
      taken_d    = 1'b0;
      illegal_d  = 1'b0;
      misalign_d = 1'b0;
    end else if (!bus.stall_i) begin
      // The shadow slot lasts a single unstalled cycle
      state_d = RUN;
      if (capture) begin
        valid_d    = 1'b1;
        taken_d    = take;
        illegal_d  = illegal;
        misalign_d = misalign;
        link_d     = info.pc + 32'd4;
        if (take) begin
          redirect_d    = 1'b1;
          redirect_pc_d = target;
          state_d       = SHADOW;
          taken_cnt_d   = taken_cnt_q + 32'd1;
        end
        if (is_ctrl_xfer(info)) begin
          br_cnt_d = br_cnt_q + 32'd1;
        end
      end else begin
        valid_d    = 1'b0;
        taken_d    = 1'b0;
        illegal_d  = 1'b0;
        misalign_d = 1'b0;
      end
    end
  end

  // Stage registers, FSM and counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= RUN;
      valid_q       <= 1'b0;
      taken_q       <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= RESET_PC;
      link_q        <= 32'd0;
      illegal_q     <= 1'b0;
      misalign_q    <= 1'b0;
      br_cnt_q      <= 32'd0;
      taken_cnt_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      taken_q       <= taken_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      link_q        <= link_d;
      illegal_q     <= illegal_d;
      misalign_q    <= misalign_d;
      br_cnt_q      <= br_cnt_d;
      taken_cnt_q   <= taken_cnt_d;
    end
  end

  assign bus.valid_o       = valid_q;
  assign bus.taken_o       = taken_q;
  assign bus.redirect_o    = redirect_q;
  assign bus.flush_o       = redirect_q;
  assign bus.redirect_pc_o = redirect_pc_q;
  assign bus.link_o        = link_q;
  assign bus.illegal_o     = illegal_q;
  assign bus.misalign_o    = misalign_q;
  assign bus.br_cnt_o      = br_cnt_q;
  assign bus.taken_cnt_o   = taken_cnt_q;
endmodule

// File: tb/tb_branch_resolve_stage.sv
// Directed bench for branch_resolve_stage with hand-computed expectations.
module tb_branch_resolve_stage;
  localparam logic [31:0] TB_RESET_PC = 32'h0000_0200;

  logic clk_i;
  logic rst_i;
  int   checks;
  int   failures;
  logic [31:0] exp_br;
  logic [31:0] exp_tk;

  branch_resolve_stage_if bus ();

  branch_resolve_stage #(.RESET_PC(TB_RESET_PC)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    bus.valid_i     = 1'b0;
    bus.stall_i     = 1'b0;
    bus.flush_i     = 1'b0;
    bus.pc_i        = 32'd0;
    bus.imm_i       = 32'd0;
    bus.rs1_data_i  = 32'd0;
    bus.rs2_data_i  = 32'd0;
    bus.funct3_i    = 3'd0;
    bus.is_branch_i = 1'b0;
    bus.is_jal_i    = 1'b0;
    bus.is_jalr_i   = 1'b0;
  endtask

  // cls: 0 = non-branch, 1 = branch, 2 = jal, 3 = jalr
  task automatic drive(input string tag, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [2:0] f3, input int cls);
    bus.valid_i     = 1'b1;
    bus.pc_i        = pc;
    bus.imm_i       = imm;
    bus.rs1_data_i  = rs1;
    bus.rs2_data_i  = rs2;
    bus.funct3_i    = f3;
    bus.is_branch_i = (cls == 1);
    bus.is_jal_i    = (cls == 2);
    bus.is_jalr_i   = (cls == 3);
    $display("tx %s pc=%h imm=%h rs1=%h rs2=%h f3=%b cls=%0d stall=%b flush=%b",
             tag, pc, imm, rs1, rs2, f3, cls, bus.stall_i, bus.flush_i);
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1'b1;
    tick();
    tick();
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
    checks++; if (bus.taken_o !== 1'b0) begin failures++; $display("FAIL reset_taken: got %b want 0", bus.taken_o); end
    checks++; if (bus.redirect_o !== 1'b0 || bus.flush_o !== 1'b0) begin failures++; $display("FAIL reset_redirect: got %b/%b want 0/0", bus.redirect_o, bus.flush_o); end
    checks++; if (bus.illegal_o !== 1'b0 || bus.misalign_o !== 1'b0) begin failures++; $display("FAIL reset_flags: got %b/%b want 0/0", bus.illegal_o, bus.misalign_o); end
    checks++; if (bus.redirect_pc_o !== TB_RESET_PC) begin failures++; $display("FAIL reset_pc: got %h want %h", bus.redirect_pc_o, TB_RESET_PC); end
    checks++; if (bus.link_o !== 32'd0) begin failures++; $display("FAIL reset_link: got %h want 0", bus.link_o); end
    checks++; if (bus.br_cnt_o !== 32'd0 || bus.taken_cnt_o !== 32'd0) begin failures++; $display("FAIL reset_cnt: got %h/%h want 0/0", bus.br_cnt_o, bus.taken_cnt_o); end
    rst_i = 1'b0;
    exp_br = 32'd0;
    exp_tk = 32'd0;
  endtask

  task automatic test_blt_signed();
    drive("blt", 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 3'b100, 1);
    tick();
    idle();
    exp_br++; exp_tk++;
    checks++; if (bus.valid_o !== 1'b1 || bus.taken_o !== 1'b1) begin failures++; $display("FAIL blt_taken: got v=%b t=%b want 1/1", bus.valid_o, bus.taken_o); end
    checks++; if (bus.redirect_o !== 1'b1 || bus.flush_o !== 1'b1) begin failures++; $display("FAIL blt_redirect: got %b/%b want 1/1", bus.redirect_o, bus.flush_o); end
    checks++; if (bus.redirect_pc_o !== 32'h120) begin failures++; $display("FAIL blt_target: got %h want 00000120", bus.redirect_pc_o); end
    checks++; if (bus.link_o !== 32'h104) begin failures++; $display("FAIL blt_link: got %h want 00000104", bus.link_o); end
    checks++; if (bus.br_cnt_o !== exp_br || bus.taken_cnt_o !== exp_tk) begin failures++; $display("FAIL blt_cnt: got %h/%h want %h/%h", bus.br_cnt_o, bus.taken_cnt_o, exp_br, exp_tk); end
    tick();
    checks++; if (bus.redirect_o !== 1'b0 || bus.flush_o !== 1'b0) begin failures++; $display("FAIL blt_pulse_width: got %b/%b want 0/0", bus.redirect_o, bus.flush_o); end
    checks++; if (bus.redirect_pc_o !== 32'h120) begin failures++; $display("FAIL blt_pc_hold: got %h want 00000120", bus.redirect_pc_o); end
  endtask

  task automatic test_bltu_unsigned();
    drive("bltu", 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 3'b110, 1);
    tick();
    idle();
    exp_br++;
    checks++; if (bus.valid_o !== 1'b1 || bus.taken_o !== 1'b0) begin failures++; $display("FAIL bltu_taken: got v=%b t=%b want 1/0", bus.valid_o, bus.taken_o); end
    checks++; if (bus.redirect_o !== 1'b0) begin failures++; $display("FAIL bltu_redirect: got %b want 0", bus.redirect_o); end
    checks++; if (bus.br_cnt_o !== exp_br || bus.taken_cnt_o !== exp_tk) begin failures++; $display("FAIL bltu_cnt: got %h/%h want %h/%h", bus.br_cnt_o, bus.taken_cnt_o, exp_br, exp_tk); end
    tick();
  endtask

  task automatic test_jalr();
    drive("jalr_align", 32'h200, 32'h4, 32'h1001, 32'h0, 3'b000, 3);
    tick();
    idle();
    exp_br++; exp_tk++;
    checks++; if (bus.taken_o !== 1'b1 || bus.redirect_o !== 1'b1) begin failures++; $display("FAIL jalr_taken: got t=%b r=%b want 1/1", bus.taken_o, bus.redirect_o); end
    checks++; if (bus.redirect_pc_o !== 32'h1004) begin failures++; $display("FAIL jalr_target: got %h want 00001004", bus.redirect_pc_o); end
    checks++; if (bus.link_o !== 32'h204) begin failures++; $display("FAIL jalr_link: got %h want 00000204", bus.link_o); end
    checks++; if (bus.misalign_o !== 1'b0) begin failures++; $display("FAIL jalr_misalign_clear: got %b want 0", bus.misalign_o); end
    tick();
    drive("jalr_misaligned", 32'h300, 32'h0, 32'h1002, 32'h0, 3'b000, 3);
    tick();
    idle();
    exp_br++;
    checks++; if (bus.misalign_o !== 1'b1 || bus.taken_o !== 1'b0) begin failures++; $display("FAIL jalr_misalign: got m=%b t=%b want 1/0", bus.misalign_o, bus.taken_o); end
    checks++; if (bus.redirect_o !== 1'b0 || bus.redirect_pc_o !== 32'h1004) begin failures++; $display("FAIL jalr_misalign_redirect: got %b pc=%h want 0 pc=00001004", bus.redirect_o, bus.redirect_pc_o); end
    checks++; if (bus.br_cnt_o !== exp_br || bus.taken_cnt_o !== exp_tk) begin failures++; $display("FAIL jalr_cnt: got %h/%h want %h/%h", bus.br_cnt_o, bus.taken_cnt_o, exp_br, exp_tk); end
    drive("illegal_f3", 32'h400, 32'h8, 32'h5, 32'h5, 3'b010, 1);
    tick();
    idle();
    exp_br++;
    checks++; if (bus.illegal_o !== 1'b1 || bus.taken_o !== 1'b0 || bus.redirect_o !== 1'b0) begin failures++; $display("FAIL illegal: got i=%b t=%b r=%b want 1/0/0", bus.illegal_o, bus.taken_o, bus.redirect_o); end
    checks++; if (bus.br_cnt_o !== exp_br || bus.taken_cnt_o !== exp_tk) begin failures++; $display("FAIL illegal_cnt: got %h/%h want %h/%h", bus.br_cnt_o, bus.taken_cnt_o, exp_br, exp_tk); end
    tick();
    checks++; if (bus.illegal_o !== 1'b0 || bus.valid_o !== 1'b0) begin failures++; $display("FAIL illegal_clear: got i=%b v=%b want 0/0", bus.illegal_o, bus.valid_o); end
  endtask

  task automatic test_conditions();
    logic [2:0]  f3_tab  [6] = '{3'b001, 3'b101, 3'b111, 3'b101, 3'b100, 3'b111};
    logic [31:0] rs1_tab [6] = '{32'h5, 32'h8000_0000, 32'h8000_0000, 32'h5, 32'h1, 32'h3};
    logic [31:0] rs2_tab [6] = '{32'h5, 32'h1, 32'h1, 32'h5, 32'hFFFF_FFFF, 32'h3};
    logic        exp_tab [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive("cond", 32'h500, 32'hFFFF_FFF8, rs1_tab[i], rs2_tab[i], f3_tab[i], 1);
      tick();
      idle();
      exp_br++;
      if (exp_tab[i]) exp_tk++;
      checks++; if (bus.taken_o !== exp_tab[i] || bus.redirect_o !== exp_tab[i]) begin failures++; $display("FAIL cond_%0d: got t=%b r=%b want %b", i, bus.taken_o, bus.redirect_o, exp_tab[i]); end
      if (exp_tab[i]) begin
        checks++; if (bus.redirect_pc_o !== 32'h4F8) begin failures++; $display("FAIL cond_target_%0d: got %h want 000004f8", i, bus.redirect_pc_o); end
      end
      tick();
    end
    checks++; if (bus.br_cnt_o !== exp_br || bus.taken_cnt_o !== exp_tk) begin failures++; $display("FAIL cond_cnt: got %h/%h want %h/%h", bus.br_cnt_o, bus.taken_cnt_o, exp_br, exp_tk); end
  endtask

  task automatic test_shadow_drop();
    drive("beq", 32'h600, 32'h40, 32'h7, 32'h7, 3'b000, 1);
    tick();
    exp_br++; exp_tk++;
    checks++; if (bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'h640) begin failures++; $display("FAIL shadow_beq: got r=%b pc=%h want 1 pc=00000640", bus.redirect_o, bus.redirect_pc_o); end
    drive("addi_wrong_path", 32'h604, 32'h1, 32'h0, 32'h0, 3'b000, 0);
    tick();
    checks++; if (bus.valid_o !== 1'b0 || bus.link_o !== 32'h604) begin failures++; $display("FAIL shadow_drop: got v=%b link=%h want 0 link=00000604", bus.valid_o, bus.link_o); end
    drive("next_instr", 32'h640, 32'h0, 32'h0, 32'h0, 3'b000, 0);
    tick();
    idle();
    checks++; if (bus.valid_o !== 1'b1 || bus.taken_o !== 1'b0 || bus.link_o !== 32'h644) begin failures++; $display("FAIL shadow_resume: got v=%b t=%b link=%h want 1/0 link=00000644", bus.valid_o, bus.taken_o, bus.link_o); end
    checks++; if (bus.br_cnt_o !== exp_br || bus.taken_cnt_o !== exp_tk) begin failures++; $display("FAIL shadow_cnt: got %h/%h want %h/%h", bus.br_cnt_o, bus.taken_cnt_o, exp_br, exp_tk); end
  endtask

  task automatic test_stall();
    drive("bne_stall", 32'h700, 32'h10, 32'h1, 32'h2, 3'b001, 1);
    tick();
    idle();
    exp_br++; exp_tk++;
    checks++; if (bus.redirect_o !== 1'b1) begin failures++; $display("FAIL stall_first_pulse: got %b want 1", bus.redirect_o); end
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.redirect_o !== 1'b0 || bus.flush_o !== 1'b0) begin failures++; $display("FAIL stall_no_repeat_%0d: got %b/%b want 0/0", i, bus.redirect_o, bus.flush_o); end
      checks++; if (bus.valid_o !== 1'b1 || bus.taken_o !== 1'b1 || bus.redirect_pc_o !== 32'h710) begin failures++; $display("FAIL stall_hold_%0d: got v=%b t=%b pc=%h want 1/1 pc=00000710", i, bus.valid_o, bus.taken_o, bus.redirect_pc_o); end
    end
    bus.stall_i = 1'b0;
    drive("wrong_path_after_stall", 32'h704, 32'h0, 32'h1, 32'h1, 3'b000, 1);
    tick();
    idle();
    checks++; if (bus.valid_o !== 1'b0 || bus.redirect_o !== 1'b0) begin failures++; $display("FAIL stall_shadow_drop: got v=%b r=%b want 0/0", bus.valid_o, bus.redirect_o); end
    checks++; if (bus.br_cnt_o !== exp_br || bus.taken_cnt_o !== exp_tk) begin failures++; $display("FAIL stall_cnt: got %h/%h want %h/%h", bus.br_cnt_o, bus.taken_cnt_o, exp_br, exp_tk); end
  endtask

  task automatic test_flush();
    bus.flush_i = 1'b1;
    bus.stall_i = 1'b1;
    drive("beq_flushed", 32'h780, 32'h40, 32'h3, 32'h3, 3'b000, 1);
    tick();
    idle();
    checks++; if (bus.valid_o !== 1'b0 || bus.taken_o !== 1'b0 || bus.redirect_o !== 1'b0) begin failures++; $display("FAIL flush_capture: got v=%b t=%b r=%b want 0/0/0", bus.valid_o, bus.taken_o, bus.redirect_o); end
    checks++; if (bus.br_cnt_o !== exp_br || bus.redirect_pc_o !== 32'h710) begin failures++; $display("FAIL flush_state: got cnt=%h pc=%h want %h pc=00000710", bus.br_cnt_o, bus.redirect_pc_o, exp_br); end
    drive("jal", 32'h800, 32'h100, 32'h0, 32'h0, 3'b000, 2);
    tick();
    idle();
    exp_br++; exp_tk++;
    checks++; if (bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'h900) begin failures++; $display("FAIL jal_target: got r=%b pc=%h want 1 pc=00000900", bus.redirect_o, bus.redirect_pc_o); end
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    checks++; if (bus.valid_o !== 1'b0 || bus.redirect_o !== 1'b0) begin failures++; $display("FAIL flush_shadow: got v=%b r=%b want 0/0", bus.valid_o, bus.redirect_o); end
    drive("after_flush", 32'h820, 32'h0, 32'h0, 32'h0, 3'b000, 0);
    tick();
    idle();
    checks++; if (bus.valid_o !== 1'b1 || bus.link_o !== 32'h824) begin failures++; $display("FAIL flush_to_run: got v=%b link=%h want 1 link=00000824", bus.valid_o, bus.link_o); end
  endtask

  task automatic test_reset_in_shadow();
    drive("jal_pre_reset", 32'hA00, 32'h8, 32'h0, 32'h0, 3'b000, 2);
    tick();
    checks++; if (bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'hA08) begin failures++; $display("FAIL rst_setup: got r=%b pc=%h want 1 pc=00000a08", bus.redirect_o, bus.redirect_pc_o); end
    rst_i = 1'b1;
    drive("branch_during_reset", 32'hA04, 32'h0, 32'h1, 32'h1, 3'b000, 1);
    tick();
    rst_i = 1'b0;
    exp_br = 32'd0;
    exp_tk = 32'd0;
    checks++; if (bus.valid_o !== 1'b0 || bus.taken_o !== 1'b0 || bus.redirect_o !== 1'b0 || bus.flush_o !== 1'b0) begin failures++; $display("FAIL rst_shadow_ctl: got v=%b t=%b r=%b f=%b want 0", bus.valid_o, bus.taken_o, bus.redirect_o, bus.flush_o); end
    checks++; if (bus.redirect_pc_o !== TB_RESET_PC || bus.link_o !== 32'd0) begin failures++; $display("FAIL rst_shadow_pc: got pc=%h link=%h want %h/0", bus.redirect_pc_o, bus.link_o, TB_RESET_PC); end
    checks++; if (bus.br_cnt_o !== 32'd0 || bus.taken_cnt_o !== 32'd0) begin failures++; $display("FAIL rst_shadow_cnt: got %h/%h want 0/0", bus.br_cnt_o, bus.taken_cnt_o); end
    drive("post_reset", 32'hB00, 32'h0, 32'h0, 32'h0, 3'b000, 0);
    tick();
    idle();
    checks++; if (bus.valid_o !== 1'b1 || bus.link_o !== 32'hB04) begin failures++; $display("FAIL rst_shadow_discard: got v=%b link=%h want 1 link=00000b04", bus.valid_o, bus.link_o); end
  endtask

  task automatic test_wrap();
    force dut.br_cnt_q    = 32'hFFFF_FFFF;
    force dut.taken_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.br_cnt_q;
    release dut.taken_cnt_q;
    drive("beq_wrap", 32'hFFFF_FFF0, 32'h20, 32'h9, 32'h9, 3'b000, 1);
    tick();
    idle();
    checks++; if (bus.br_cnt_o !== 32'd0 || bus.taken_cnt_o !== 32'd0) begin failures++; $display("FAIL wrap_cnt: got %h/%h want 0/0", bus.br_cnt_o, bus.taken_cnt_o); end
    checks++; if (bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'h10) begin failures++; $display("FAIL wrap_target: got r=%b pc=%h want 1 pc=00000010", bus.redirect_o, bus.redirect_pc_o); end
    checks++; if (bus.link_o !== 32'hFFFF_FFF4) begin failures++; $display("FAIL wrap_link: got %h want fffffff4", bus.link_o); end
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_i    = 1'b1;
    idle();
    test_reset();
    test_blt_signed();
    test_bltu_unsigned();
    test_jalr();
    test_conditions();
    test_shadow_drop();
    test_stall();
    test_flush();
    test_reset_in_shadow();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
